// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush and saturating stall counter
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_in,
    input  logic [1:0]        mem_in,
    input  logic [3:0]        ex_in,
    input  logic [DATA_W-1:0] pc4_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              flush,
    output logic [1:0]        wb_out,
    output logic [1:0]        mem_out,
    output logic [3:0]        ex_out,
    output logic [DATA_W-1:0] pc4_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);
    logic w_stall;
    logic w_bubble;

    // A load in EX whose destination feeds the ID instruction must wait one cycle; a flush overrides it
    assign w_stall = mem_out[1] & (rt_out != '0) & ((rt_out == rs_in) | (rt_out == rt_in)) & ~flush;
    assign w_bubble = flush | w_stall;
    assign stall = w_stall;
    assign pc_write = ~w_stall;
    assign if_id_write = ~w_stall;

    // Pipeline register: control zeroed on flush or stall, data always follows the inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_out      <= '0;
            mem_out     <= '0;
            ex_out      <= '0;
            pc4_out     <= '0;
            rd1_out     <= '0;
            rd2_out     <= '0;
            imm_out     <= '0;
            rs_out      <= '0;
            rt_out      <= '0;
            rd_out      <= '0;
            stall_count <= '0;
        end else begin
            wb_out      <= w_bubble ? 2'b00 : wb_in;
            mem_out     <= w_bubble ? 2'b00 : mem_in;
            ex_out      <= w_bubble ? 4'b0000 : ex_in;
            pc4_out     <= pc4_in;
            rd1_out     <= rd1_in;
            rd2_out     <= rd2_in;
            imm_out     <= imm_in;
            rs_out      <= rs_in;
            rt_out      <= rt_in;
            rd_out      <= rd_in;
            stall_count <= (w_stall && stall_count != '1) ? stall_count + 1'b1 : stall_count;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_in, mem_in;
    logic [3:0]  ex_in;
    logic [31:0] pc4_in, rd1_in, rd2_in, imm_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic        flush;
    logic [1:0]  wb_out, mem_out, s_wb_out, s_mem_out;
    logic [3:0]  ex_out, s_ex_out;
    logic [31:0] pc4_out, rd1_out, rd2_out, imm_out, s_pc4_out, s_rd1_out, s_rd2_out, s_imm_out;
    logic [4:0]  rs_out, rt_out, rd_out, s_rs_out, s_rt_out, s_rd_out;
    logic        pc_write, if_id_write, stall, s_pc_write, s_if_id_write, s_stall;
    logic [15:0] stall_count;
    logic [1:0]  s_stall_count;

    int n_chk = 0;
    int n_fail = 0;

    // Model of the latched instruction and the stall counters
    logic [1:0]  m_wb, m_mem;
    logic [3:0]  m_ex;
    logic [31:0] m_pc4, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    int          m_cnt, m_cnt2;
    bit          m_valid = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .wb_in(wb_in), .mem_in(mem_in), .ex_in(ex_in),
        .pc4_in(pc4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
        .wb_out(wb_out), .mem_out(mem_out), .ex_out(ex_out),
        .pc4_out(pc4_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .pc_write(pc_write), .if_id_write(if_id_write), .stall(stall), .stall_count(stall_count)
    );

    id_ex_stage #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .wb_in(wb_in), .mem_in(mem_in), .ex_in(ex_in),
        .pc4_in(pc4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
        .wb_out(s_wb_out), .mem_out(s_mem_out), .ex_out(s_ex_out),
        .pc4_out(s_pc4_out), .rd1_out(s_rd1_out), .rd2_out(s_rd2_out), .imm_out(s_imm_out),
        .rs_out(s_rs_out), .rt_out(s_rt_out), .rd_out(s_rd_out),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .stall(s_stall), .stall_count(s_stall_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hazard as described: a latched load writing a nonzero register read by the ID instruction
    function automatic bit exp_stall();
        bit is_load = m_mem[1];
        bit uses = (m_rt == rs_in) || (m_rt == rt_in);
        return is_load && m_rt != 0 && uses && !flush;
    endfunction

    task automatic drive(input logic r, input logic [1:0] wb, input logic [1:0] mem, input logic [3:0] ex,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic fl);
        rst = r; wb_in = wb; mem_in = mem; ex_in = ex;
        rs_in = rs; rt_in = rt; rd_in = rd; flush = fl;
        pc4_in = $urandom; rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom;
    endtask

    task automatic cycle();
        bit s;
        #1;
        s = m_valid && !rst && exp_stall();
        if (m_valid && !rst) begin
            chk("stall", stall, s);
            chk("pc_write", pc_write, !s);
            chk("if_id_write", if_id_write, !s);
            chk("s_stall", s_stall, s);
        end
        @(posedge clk);
        if (rst) begin
            {m_wb, m_mem, m_ex} = '0;
            {m_pc4, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd} = '0;
            m_cnt = 0;
            m_cnt2 = 0;
            m_valid = 1;
        end else begin
            if (flush || s) {m_wb, m_mem, m_ex} = '0;
            else begin m_wb = wb_in; m_mem = mem_in; m_ex = ex_in; end
            m_pc4 = pc4_in; m_rd1 = rd1_in; m_rd2 = rd2_in; m_imm = imm_in;
            m_rs = rs_in; m_rt = rt_in; m_rd = rd_in;
            if (s) begin
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
            end
        end
        #1;
        chk("wb_out", wb_out, m_wb);
        chk("mem_out", mem_out, m_mem);
        chk("ex_out", ex_out, m_ex);
        chk("pc4_out", pc4_out, m_pc4);
        chk("rd1_out", rd1_out, m_rd1);
        chk("rd2_out", rd2_out, m_rd2);
        chk("imm_out", imm_out, m_imm);
        chk("rs_out", rs_out, m_rs);
        chk("rt_out", rt_out, m_rt);
        chk("rd_out", rd_out, m_rd);
        chk("stall_count", stall_count, m_cnt);
        chk("s_stall_count", s_stall_count, m_cnt2);
        chk("s_wb_out", s_wb_out, m_wb);
    endtask

    task automatic do_reset();
        drive(1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        cycle();
        drive(1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        cycle();
        drive(0, 2'b00, 2'b00, 4'h0, 5'd0, 5'd0, 5'd0, 0);
        #1;
        chk("rst_pc_write", pc_write, 1);
        chk("rst_stall", stall, 0);
        chk("rst_count", stall_count, 0);
        chk("rst_mem_out", mem_out, 0);
    endtask

    initial begin
        int sat_exp[5] = '{1, 2, 3, 3, 3};
        @(posedge clk);
        #1;
        do_reset();

        // R-type pass-through
        drive(0, 2'b10, 2'b00, 4'b1100, 5'd1, 5'd2, 5'd8, 0);
        rd1_in = 32'h11; rd2_in = 32'h22;
        cycle();
        chk("r_wb", wb_out, 2'b10);
        chk("r_ex", ex_out, 4'b1100);
        chk("r_rd1", rd1_out, 32'h11);
        chk("r_rd2", rd2_out, 32'h22);
        chk("r_rd", rd_out, 5'd8);

        // Load-use: lw $9 then consumer of $9
        drive(0, 2'b11, 2'b10, 4'b0001, 5'd3, 5'd9, 5'd0, 0);
        cycle();
        drive(0, 2'b10, 2'b00, 4'b1100, 5'd9, 5'd10, 5'd11, 0);
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_if_id_write", if_id_write, 0);
        cycle();
        chk("lu_bubble_wb", wb_out, 0);
        chk("lu_bubble_mem", mem_out, 0);
        chk("lu_bubble_ex", ex_out, 0);
        chk("lu_count", stall_count, 1);
        #1;
        chk("lu_stall_after", stall, 0);
        cycle();
        chk("lu_replay_wb", wb_out, 2'b10);

        // Load to $0 never stalls
        drive(0, 2'b11, 2'b10, 4'b0001, 5'd3, 5'd0, 5'd0, 0);
        cycle();
        drive(0, 2'b10, 2'b00, 4'b1100, 5'd0, 5'd4, 5'd5, 0);
        #1;
        chk("z_stall", stall, 0);
        cycle();
        chk("z_wb", wb_out, 2'b10);
        chk("z_count", stall_count, 1);

        // Flush beats load-use
        drive(0, 2'b11, 2'b10, 4'b0001, 5'd3, 5'd9, 5'd0, 0);
        cycle();
        drive(0, 2'b10, 2'b00, 4'b1100, 5'd9, 5'd10, 5'd11, 1);
        #1;
        chk("f_stall", stall, 0);
        chk("f_pc_write", pc_write, 1);
        cycle();
        chk("f_wb", wb_out, 0);
        chk("f_ex", ex_out, 0);
        chk("f_count", stall_count, 1);

        // Saturation of the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 2'b11, 2'b10, 4'b0001, 5'd1, 5'd5, 5'd0, 0);
            cycle();
            drive(0, 2'b10, 2'b00, 4'b1100, 5'd5, 5'd6, 5'd7, 0);
            cycle();
            chk($sformatf("sat_%0d", i), s_stall_count, sat_exp[i]);
        end

        // Randomized traffic with a small register pool to provoke hazards
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 49) == 0), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. It sits directly downstream of the main control decoder and the register file.
- Latches the decoder's WB/MEM/EX control bundles together with the ID-stage datapath values, and hands them to the EX stage.
- Contains the load-use hazard detector. On a hazard it freezes PC and IF/ID and inserts a bubble.
- Handles branch/jump flush and keeps a saturating stall counter for performance.

Parameters:
- DATA_W, 32, width of PC+4, register operands and sign-extended immediate
- REG_W, 5, register specifier width
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- wb_in  input  2  {RegWrite, MemToReg} from control decoder
- mem_in  input  2  {MemRead, MemWrite} from control decoder
- ex_in  input  4  {RegDest, ALUOp[1:0], ALUSrc} from control decoder
- pc4_in  input  DATA_W  PC+4 of ID instruction
- rd1_in  input  DATA_W  register file read data 1
- rd2_in  input  DATA_W  register file read data 2
- imm_in  input  DATA_W  sign-extended immediate
- rs_in  input  REG_W  instr[25:21] of ID instruction
- rt_in  input  REG_W  instr[20:16]
- rd_in  input  REG_W  instr[15:11]
- flush  input  1  branch taken or jump resolved; kill ID instruction
- wb_out  output  2  registered WB bundle
- mem_out  output  2  registered MEM bundle
- ex_out  output  4  registered EX bundle
- pc4_out, rd1_out, rd2_out, imm_out  output  DATA_W each  registered data
- rs_out, rt_out, rd_out  output  REG_W each  registered specifiers
- pc_write  output  1  combinational; 0 freezes PC
- if_id_write  output  1  combinational; 0 freezes IF/ID
- stall  output  1  combinational; load-use hazard active this cycle
- stall_count  output  CNT_W  registered count of stall cycles, saturating

Behaviour:
- Reset (rst=1 at edge): every registered output is 0, including all control bundles and stall_count. A zero bundle is a NOP.
- Hazard (combinational): `stall = mem_out[1] & (rt_out != 0) & ((rt_out == rs_in) | (rt_out == rt_in)) & ~flush`.
- Gating: `pc_write = if_id_write = ~stall`.
- Register update, priority rst > flush > stall > normal:
  - flush=1: wb_out, mem_out and ex_out load 0. Data and specifier fields load inputs; they are don't-care but must be deterministic.
  - stall=1: control bundles load 0 (bubble). Data fields load inputs. Because IF/ID is frozen, the same instruction is re-presented next cycle.
  - otherwise: all fields load their inputs.
- Latency: exactly 1 cycle from input to output.
- Stall duration: a load-use stall lasts exactly one cycle. After the bubble, mem_out[1]=0, so the stall cannot self-sustain.
- Flush during hazard: flush wins. There is no stall, pc_write=1 so the redirect proceeds, the bubble is inserted, and stall_count does not increment.
- stall_count increments by 1 on each edge where stall=1 and rst=0. It holds at 2^CNT_W-1.
- Load targeting $0 never stalls.
- MemWrite (sw) in ID/EX never triggers a stall; only MemRead does.
- Reset asserted mid-stall: the next edge clears everything and pc_write returns to 1, because mem_out becomes 0.
- No X propagation: all case/mux defaults drive 0.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, stall_count=0, pc_write=1.
- R-type pass-through: wb_in=2'b10, mem_in=0, ex_in=4'b1100, rd1_in=32'h11, rd2_in=32'h22, rd_in=5'd8 -> exactly one cycle later outputs match; stall=0 throughout.
- Load-use: cycle N latches lw (mem_in=2'b10, rt_in=5'd9). Cycle N+1 presents add with rs_in=5'd9 -> stall=1, pc_write=0, if_id_write=0. Cycle N+2: wb_out/mem_out/ex_out=0, stall=0, stall_count=1.
- Load to $0: lw with rt=0, followed by consumer with rs=0 -> stall stays 0, no bubble, stall_count unchanged.
- Flush priority: the load-use condition from the previous test with flush=1 on the same cycle -> stall=0, pc_write=1, bundles 0 next cycle, stall_count unchanged.
- Saturation with CNT_W=2: force 5 separate load-use stalls -> stall_count sequence 1,2,3,3,3.
